// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the memory-port arbiter.
package mem_arbiter_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_RISE = 3'd2,
    WAIT_FALL = 3'd3,
    DONE      = 3'd4
  } state_t;

  localparam logic [1:0] GRANT_NONE = 2'd3;
  localparam int ADDR_W = 27;
  localparam int DATA_W = 32;
  localparam int RR_N   = 3;

endpackage

// File: rtl/mem_arbiter_rr_arbiter3.sv
// Combinational 3-way round-robin pick: first set request scanning ptr, ptr+1, ptr+2.
module rr_arbiter3
  import mem_arbiter_pkg::*;
(
  input  logic [RR_N-1:0] req,
  input  logic [1:0]      ptr,
  output logic [1:0]      idx,
  output logic            any
);

  logic [2:0] pos;

  // Scan from the farthest slot back to ptr so the nearest set request wins.
  always_comb begin
    idx = 2'd0;
    pos = 3'd0;
    any = |req;
    for (int k = RR_N - 1; k >= 0; k--) begin
      pos = {1'b0, ptr} + 3'(k);
      if (pos >= 3'(RR_N)) pos = pos - 3'(RR_N);
      if (req[pos[1:0]]) idx = pos[1:0];
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory-unit port among three requesters with round-robin grants,
// start/busy handshake sequencing and a saturating transaction timeout.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int N_REQ          = 3,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int TO_W           = 13
)(
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  input  logic [N_REQ-1:0]        req_we,
  output logic [N_REQ-1:0]        req_done,
  output logic                    req_err,
  output logic [DATA_W-1:0]       rd_q,
  output logic [1:0]              grant_id,
  output logic [ADDR_W-1:0]       mem_address,
  output logic [DATA_W-1:0]       mem_data,
  output logic                    mem_we,
  output logic                    mem_start,
  input  logic                    mem_busy,
  input  logic [DATA_W-1:0]       mem_q,
  input  logic                    mem_init_done
);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  state_t            state;
  logic [1:0]        rr_ptr;
  logic [TO_W-1:0]   to_cnt;
  logic [1:0]        win_idx;
  logic              win_any;
  logic [ADDR_W-1:0] addr_arr [N_REQ];
  logic [DATA_W-1:0] data_arr [N_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign addr_arr[gi] = req_addr[gi*ADDR_W +: ADDR_W];
      assign data_arr[gi] = req_data[gi*DATA_W +: DATA_W];
    end
  endgenerate

  rr_arbiter3 u_rr (
    .req (req_valid),
    .ptr (rr_ptr),
    .idx (win_idx),
    .any (win_any)
  );

  logic            to_hit;
  logic [TO_W-1:0] to_cnt_inc;
  assign to_hit     = (to_cnt == TO_LAST);
  assign to_cnt_inc = (to_cnt == '1) ? to_cnt : to_cnt + 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      mem_start   <= 1'b0;
      mem_we      <= 1'b0;
      mem_address <= '0;
      mem_data    <= '0;
      req_done    <= '0;
      req_err     <= 1'b0;
      rd_q        <= '0;
      grant_id    <= GRANT_NONE;
      rr_ptr      <= 2'd0;
      to_cnt      <= '0;
    end else begin
      req_done <= '0;
      case (state)
        IDLE: begin
          if (mem_init_done && win_any) begin
            mem_address <= addr_arr[win_idx];
            mem_data    <= data_arr[win_idx];
            mem_we      <= req_we[win_idx];
            grant_id    <= win_idx;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          mem_start <= 1'b1;
          to_cnt    <= '0;
          state     <= WAIT_RISE;
        end
        WAIT_RISE: begin
          if (mem_busy) begin
            to_cnt <= '0;
            state  <= WAIT_FALL;
          end else if (to_hit) begin
            mem_start          <= 1'b0;
            rd_q               <= '0;
            req_err            <= 1'b1;
            req_done[grant_id] <= 1'b1;
            state              <= DONE;
          end else begin
            to_cnt <= to_cnt_inc;
          end
        end
        WAIT_FALL: begin
          // The done pulse is registered here so it is visible during DONE,
          // letting the requester drop req_valid before the next IDLE scan.
          if (!mem_busy) begin
            mem_start          <= 1'b0;
            rd_q               <= mem_q;
            req_err            <= 1'b0;
            req_done[grant_id] <= 1'b1;
            state              <= DONE;
          end else if (to_hit) begin
            mem_start          <= 1'b0;
            rd_q               <= '0;
            req_err            <= 1'b1;
            req_done[grant_id] <= 1'b1;
            state              <= DONE;
          end else begin
            to_cnt <= to_cnt_inc;
          end
        end
        DONE: begin
          rr_ptr   <= (grant_id == 2'd2) ? 2'd0 : grant_id + 2'd1;
          grant_id <= GRANT_NONE;
          mem_we   <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single memory-unit port (address/data/we/start in; busy/q out) among three requesters:
  - port 0: CPU instruction fetch
  - port 1: CPU data access
  - port 2: DMA/copy engine
- Owns the start/busy sequencing: start stays high until busy has risen and then fallen, and drops the same cycle busy falls.
- Arbitrates round-robin between requesters, returns read data with a per-port done pulse, and aborts hung transactions with a timeout.

Parameters:
- N_REQ, 3, number of requesters; fixed at 3 in this revision.
- TIMEOUT_CYCLES, 4096, cycles allowed in WAIT_RISE or WAIT_FALL before abort.
- TO_W, 13, width of the timeout counter; must satisfy 2^TO_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  3  per-port request; held high until that port's req_done.
- req_addr  in  81  packed 3x27 addresses; port i at [27i+26:27i].
- req_data  in  96  packed 3x32 write data.
- req_we  in  3  per-port write enable.
- req_done  out  3  one-cycle pulse to the served port.
- req_err  out  1  valid with req_done; 1 = transaction timed out.
- rd_q  out  32  read data, valid in the req_done cycle.
- grant_id  out  2  index of the port being served; 3 = none.
- mem_address  out  27  to memory unit.
- mem_data  out  32  to memory unit.
- mem_we  out  1  to memory unit.
- mem_start  out  1  to memory unit.
- mem_busy  in  1  from memory unit.
- mem_q  in  32  from memory unit.
- mem_init_done  in  1  from memory unit; no grants while low.

Behaviour:
- Reset values (async, reset=0):
  - state IDLE; mem_start 0; mem_we 0; mem_address 0; mem_data 0.
  - req_done 0; req_err 0; rd_q 0; grant_id 3.
  - rr_ptr 0; timeout counter 0.
- State machine: IDLE -> ISSUE -> WAIT_RISE -> WAIT_FALL -> DONE -> IDLE.
- IDLE:
  - Leaves only when mem_init_done=1 and any req_valid is set.
  - Winner is the first set port scanning rr_ptr, rr_ptr+1, rr_ptr+2 (mod 3).
  - Latches the winner's addr/data/we into mem_* registers and sets grant_id.
  - Goes to ISSUE.
- ISSUE: mem_start=1 (registered); go to WAIT_RISE; clear the timeout counter.
- WAIT_RISE:
  - mem_start stays 1.
  - On mem_busy=1, go to WAIT_FALL and clear the counter.
  - Else, when the counter reaches TIMEOUT_CYCLES-1, abort to DONE with err=1.
- WAIT_FALL:
  - mem_start stays 1.
  - On mem_busy=0, capture mem_q into rd_q, drop mem_start that same cycle (registered 0), and go to DONE with err=0.
  - On timeout, abort to DONE with err=1, rd_q=0, mem_start=0.
- DONE:
  - req_done[grant_id]=1 for exactly one cycle; req_err=err.
  - rr_ptr = grant_id+1 mod 3; grant_id=3; mem_we=0; go to IDLE.
- Latency (no contention): req_valid seen in IDLE -> req_done = 3 cycles + memory busy time.
- Min spacing: back-to-back grants are 1 IDLE cycle apart, so mem_start is low for at least 2 cycles between transactions (ISSUE re-raises it).
- A requester must deassert req_valid in the cycle after req_done, or the arbiter treats it as a new request. The round-robin pointer prevents one port holding the bus twice while another waits.
- req_valid dropping mid-transaction: ignored; the transaction completes and done still pulses.
- mem_init_done dropping mid-transaction: ignored; only gates new grants.
- Reset asserted mid-transaction: all state cleared asynchronously; no done pulse issued.
- Timeout arithmetic: the counter saturates and never wraps.
- Addresses are passed through unmodified; region decode stays in the memory unit.

Decomposition:
- Shared package holds:
  - state encoding: IDLE=0, ISSUE=1, WAIT_RISE=2, WAIT_FALL=3, DONE=4.
  - GRANT_NONE=2'd3.
  - widths: ADDR_W=27, DATA_W=32.
- One sub-module: rr_arbiter3 (combinational 3-way round-robin pick from req_valid and rr_ptr, outputs idx and any).
- FSM, latching and timeout logic stay in the top.

Test Plan:
- Single read: port1 requests addr 0x000010; memory model raises busy 1 cycle after start and holds it 5 cycles, then q=0xDEADBEEF -> mem_start high 7 cycles and drops the cycle busy falls; req_done=3'b010; rd_q=0xDEADBEEF; req_err=0.
- Contention: all three ports assert together with rr_ptr=0 -> grant order 0,1,2; port0 re-asserts after done -> it is served after 2; each done pulse is exactly 1 cycle.
- Write pass-through: port2 writes 0x12345678 to 0xC00420 -> mem_address=0xC00420, mem_data=0x12345678, mem_we=1 for the whole transaction; we is 0 after DONE.
- Timeout: memory model never raises busy -> req_done after TIMEOUT_CYCLES+2 cycles with req_err=1, rd_q=0, mem_start=0.
- Init gating: mem_init_done=0 with port0 valid for 100 cycles -> mem_start never rises; it rises 2 cycles after mem_init_done goes to 1.
- Async reset in WAIT_FALL: reset low for 1 cycle -> all outputs return to reset values immediately; no req_done pulse; the next request is served normally.
